// File: rtl/if_instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding and word framing constants.
package if_instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam int          BYTES_PER_INST    = 4;
    localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/if_loader_word_assembler.sv
// Shifts incoming bytes MSB-first into a word; word_ready flags the byte that completes it.
// The reset port is active-low and asynchronous, matching the top level.
module if_loader_word_assembler
    import if_instruction_loader_pkg::*;
#(
    parameter int NB_INST = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               valid,
    input  logic [NB_BYTE-1:0] data,
    output logic [NB_INST-1:0] word,
    output logic               word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INST - 1);

    logic [NB_INST-1:0] word_q, word_d;
    logic [1:0]         cnt_q, cnt_d;

    // word already includes the byte being accepted, so the caller can latch it on the completing edge
    always_comb begin
        word       = {word_q[NB_INST-NB_BYTE-1:0], data};
        word_ready = valid && (cnt_q == LAST_BYTE);
        word_d     = word_q;
        cnt_d      = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (valid) begin
            word_d = word;
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/if_instruction_loader.sv
// Byte-stream to instruction-memory writer: assembles 32-bit words and writes them at
// consecutive word addresses until HALT is written or the memory runs out.
module if_instruction_loader
    import if_instruction_loader_pkg::*;
#(
    parameter int                NB_ADDR   = 32,
    parameter int                NB_INST   = 32,
    parameter int                NB_BYTE   = 8,
    parameter int                MEM_DEPTH = 256,
    parameter logic [NB_INST-1:0] HALT_INST = NB_INST'(HALT_INST_DEFAULT)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_write,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_address,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR-1:0] o_word_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'((MEM_DEPTH - 1) * BYTES_PER_INST);
    localparam logic [NB_ADDR-1:0] ADDR_STEP = NB_ADDR'(BYTES_PER_INST);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR-1:0] count_q, count_d;
    logic [NB_ADDR-1:0] waddr_q, waddr_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic               write_q, write_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               asm_clear, asm_valid, asm_ready;
    logic [NB_INST-1:0] asm_word;

    if_loader_word_assembler #(
        .NB_INST (NB_INST),
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (asm_clear),
        .valid      (asm_valid),
        .data       (i_rx_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        waddr_d   = waddr_q;
        inst_d    = inst_q;
        write_d   = 1'b0;
        done_d    = done_q;
        ovf_d     = ovf_q;
        asm_clear = 1'b0;
        asm_valid = 1'b0;
        case (state_q)
            ST_RECV: begin
                asm_valid = i_rx_valid;
                if (asm_ready) begin
                    state_d = ST_WRITE;
                    write_d = 1'b1;
                    inst_d  = asm_word;
                    waddr_d = addr_q;
                end
            end
            ST_WRITE: begin
                count_d = count_q + 1'b1;
                // HALT takes priority, so a HALT in the last slot still ends cleanly
                if (inst_q == HALT_INST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_ERROR;
                    ovf_d   = 1'b1;
                end else begin
                    state_d   = ST_RECV;
                    addr_d    = addr_q + ADDR_STEP;
                    asm_valid = i_rx_valid;
                end
            end
            default: begin
                if (i_start) begin
                    state_d   = ST_RECV;
                    addr_d    = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    ovf_d     = 1'b0;
                    asm_clear = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            waddr_q <= '0;
            inst_q  <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            inst_q  <= inst_d;
            write_q <= write_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_busy        = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign o_write       = write_q;
    assign o_instruction = inst_q;
    assign o_address     = waddr_q;
    assign o_done        = done_q;
    assign o_overflow    = ovf_q;
    assign o_word_count  = count_q;

endmodule

// File: tb/tb_if_instruction_loader.sv
// Directed bench for the instruction loader, built with a four-word memory.
module tb_if_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [31:0] wcnt;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;
    int wr_base = 0;

    if_instruction_loader #(
        .NB_ADDR   (32),
        .NB_INST   (32),
        .NB_BYTE   (8),
        .MEM_DEPTH (4),
        .HALT_INST (32'hFFFF_FFFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .o_write       (wr),
        .o_instruction (inst),
        .o_address     (addr),
        .o_busy        (busy),
        .o_done        (done),
        .o_overflow    (ovf),
        .o_word_count  (wcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr === 1'b1) wr_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    // Returns on the falling edge inside the WRITE cycle
    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic chk_write(input string tag, input logic [31:0] exp_inst, input logic [31:0] exp_addr);
        chk({tag, "_wr"},   {31'd0, wr},   32'd1);
        chk({tag, "_inst"}, inst,          exp_inst);
        chk({tag, "_addr"}, addr,          exp_addr);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_write", {31'd0, wr}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_wcnt", wcnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single word
        send_byte(8'h12);
        chk("idle_byte_ignored_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        send_word(32'h8C01_0004);
        chk_write("w0", 32'h8C01_0004, 32'd0);
        chk("w0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("w0_pulse_end", {31'd0, wr}, 32'd0);
        chk("w0_wcnt", wcnt, 32'd1);

        // Three more words ending with HALT in the last slot
        send_word(32'h1122_3344);
        chk_write("w1", 32'h1122_3344, 32'd4);
        send_word(32'h5566_7788);
        chk_write("w2", 32'h5566_7788, 32'd8);
        send_word(32'hFFFF_FFFF);
        chk_write("halt", 32'hFFFF_FFFF, 32'd12);
        @(negedge clk);
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_ovf", {31'd0, ovf}, 32'd0);
        chk("halt_wcnt", wcnt, 32'd4);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        send_word(32'hAABB_CCDD);
        @(negedge clk);
        chk("done_writes", wr_seen, 4);
        chk("done_held", {31'd0, done}, 32'd1);

        // Restart after DONE; a start pulse mid-word must not disturb assembly
        pulse_start();
        chk("restart_done_clr", {31'd0, done}, 32'd0);
        chk("restart_wcnt", wcnt, 32'd0);
        wr_base = wr_seen;
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk_write("rs0", 32'hDEAD_BEEF, 32'd0);

        // Byte arriving during the WRITE cycle becomes byte 0 of the next word
        rx_valid = 1'b1; rx_data = 8'hA1;
        @(negedge clk); rx_valid = 1'b0;
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        chk_write("overlap", 32'hA1A2_A3A4, 32'd4);

        // Fill the memory without HALT
        send_word(32'h0000_0001);
        chk_write("f2", 32'h0000_0001, 32'd8);
        send_word(32'h0000_0002);
        chk_write("f3", 32'h0000_0002, 32'd12);
        @(negedge clk);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        chk("ovf_done", {31'd0, done}, 32'd0);
        chk("ovf_busy", {31'd0, busy}, 32'd0);
        chk("ovf_wcnt", wcnt, 32'd4);
        send_word(32'h0000_0003);
        @(negedge clk);
        chk("ovf_no_fifth", wr_seen - wr_base, 4);
        chk("ovf_addr_held", addr, 32'd12);

        // Asynchronous reset in the middle of a word
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        wr_base = wr_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_addr", addr, 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        chk("arst_wcnt", wcnt, 32'd0);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("arst_no_write", wr_seen - wr_base, 0);
        @(negedge clk); rst_n = 1'b1;

        // Start and byte together from IDLE: the byte is dropped
        @(negedge clk); start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk); start = 1'b0; rx_valid = 1'b0;
        send_word(32'hB1B2_B3B4);
        chk_write("post_rst", 32'hB1B2_B3B4, 32'd0);
        @(negedge clk);
        chk("post_rst_wcnt", wcnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
